// File: rtl/sram_responder.sv
// sram_responder: on-chip SRAM stand-in for the SLC-3 control unit strobes.
// Strobes are active-low and sampled on posedge Clk.
// Reads return data after a configurable registered latency. Writes commit
// once per WE strobe and honour the byte lanes.
// Option macro: SRAM_RESPONDER_SWITCH_IO_EN maps address 0xFFFF to Switches
// for reads and to Hex_out for writes.
module sram_responder #(
  parameter int ADDR_W     = 16,
  parameter int DEPTH_LOG2 = 10,
  parameter int READ_LAT   = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Mem_CE,
  input  logic              Mem_UB,
  input  logic              Mem_LB,
  input  logic              Mem_OE,
  input  logic              Mem_WE,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [15:0]       Data_from_CPU,
  output logic [15:0]       Data_to_CPU,
  output logic              Rd_valid,
  input  logic [15:0]       Switches,
  output logic [15:0]       Hex_out
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_WAIT  = 2'd1,
    RD_DRIVE = 2'd2,
    WR_HOLD  = 2'd3
  } state_t;

  state_t                  state_reg, state_next;
  logic [2:0]              cnt_reg, cnt_next;
  logic [15:0]             data_reg, data_next;
  logic                    valid_reg, valid_next;
  logic [DEPTH_LOG2-1:0]   addr_reg, addr_next;
  logic                    io_reg, io_next;
  logic [15:0]             hex_reg, hex_next;

  logic [15:0]             mem_array [0:DEPTH-1];

  logic                    active;
  logic                    write_req;
  logic                    read_req;
  logic                    do_write;
  logic                    mem_we;
  logic                    io_cur;
  logic [DEPTH_LOG2-1:0]   cur_idx;
  logic [15:0]             cur_word;
  logic [15:0]             lat_word;

  assign active    = ~Mem_CE;
  assign write_req = active & ~Mem_WE;
  assign read_req  = active & ~Mem_OE;
  assign cur_idx   = ADDR[DEPTH_LOG2-1:0];

`ifdef SRAM_RESPONDER_SWITCH_IO_EN
  // The I/O address is decoded on the full bus, before the wrap to the array.
  assign io_cur = (ADDR == {ADDR_W{1'b1}});
`else
  logic unused_addr_bits;
  assign io_cur           = 1'b0;
  assign unused_addr_bits = ^ADDR;
`endif

  // Read sources: the live address (first load at latency 1 and the RD_DRIVE
  // refresh) and the address latched when the read started (RD_WAIT load).
  assign cur_word = io_cur ? Switches : mem_array[cur_idx];
  assign lat_word = io_reg ? Switches : mem_array[addr_reg];

  // Disabled lanes read back as zero.
  function automatic logic [15:0] lane_mask(input logic [15:0] w,
                                            input logic ub_n,
                                            input logic lb_n);
    return {(ub_n ? 8'h00 : w[15:8]), (lb_n ? 8'h00 : w[7:0])};
  endfunction

  // Next-state, read-data and write-commit decisions for the strobe FSM.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    data_next  = data_reg;
    valid_next = valid_reg;
    addr_next  = addr_reg;
    io_next    = io_reg;
    hex_next   = hex_reg;
    do_write   = 1'b0;
    mem_we     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (write_req) begin
          do_write   = 1'b1;
          valid_next = 1'b0;
          state_next = WR_HOLD;
        end else if (read_req) begin
          addr_next = cur_idx;
          io_next   = io_cur;
          if (READ_LAT <= 1) begin
            data_next  = lane_mask(cur_word, Mem_UB, Mem_LB);
            valid_next = 1'b1;
            state_next = RD_DRIVE;
          end else begin
            cnt_next   = 3'(READ_LAT - 1);
            state_next = RD_WAIT;
          end
        end
      end

      RD_WAIT: begin
        if (write_req) begin
          // A write strobe overrides the pending read.
          do_write   = 1'b1;
          valid_next = 1'b0;
          cnt_next   = 3'd0;
          state_next = WR_HOLD;
        end else if (!read_req) begin
          valid_next = 1'b0;
          cnt_next   = 3'd0;
          state_next = IDLE;
        end else if (cnt_reg <= 3'd1) begin
          data_next  = lane_mask(lat_word, Mem_UB, Mem_LB);
          valid_next = 1'b1;
          cnt_next   = 3'd0;
          state_next = RD_DRIVE;
        end else begin
          cnt_next = cnt_reg - 3'd1;
        end
      end

      RD_DRIVE: begin
        if (write_req) begin
          do_write   = 1'b1;
          valid_next = 1'b0;
          state_next = WR_HOLD;
        end else if (!read_req) begin
          valid_next = 1'b0;
          state_next = IDLE;
        end else begin
          // Follow the live address so a new address is seen one edge later.
          data_next  = lane_mask(cur_word, Mem_UB, Mem_LB);
          valid_next = 1'b1;
        end
      end

      WR_HOLD: begin
        // Hold off further commits until the strobe is released.
        if (Mem_WE) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
        valid_next = 1'b0;
        cnt_next   = 3'd0;
      end
    endcase

    if (do_write) begin
      if (io_cur) begin
        hex_next = {(Mem_UB ? hex_reg[15:8] : Data_from_CPU[15:8]),
                    (Mem_LB ? hex_reg[7:0]  : Data_from_CPU[7:0])};
      end else begin
        mem_we = 1'b1;
      end
    end
  end

  // State, read data, and I/O registers; reset also blocks any write that
  // has not committed yet. The array itself is never cleared.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 3'd0;
      data_reg  <= 16'h0000;
      valid_reg <= 1'b0;
      addr_reg  <= '0;
      io_reg    <= 1'b0;
      hex_reg   <= 16'h0000;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
      addr_reg  <= addr_next;
      io_reg    <= io_next;
      hex_reg   <= hex_next;
      if (mem_we) begin
        if (!Mem_UB) mem_array[cur_idx][15:8] <= Data_from_CPU[15:8];
        if (!Mem_LB) mem_array[cur_idx][7:0]  <= Data_from_CPU[7:0];
      end
    end
  end

  assign Data_to_CPU = data_reg;
  assign Rd_valid    = valid_reg;
  assign Hex_out     = hex_reg;

endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: directed checks for sram_responder.
// DUT A (READ_LAT=1) runs a vector table. DUT B (READ_LAT=3) runs
// hand-written latency and abort sequences.
module tb_sram_responder;

`ifdef SRAM_RESPONDER_SWITCH_IO_EN
  localparam bit IO_EN = 1'b1;
`else
  localparam bit IO_EN = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset;

  logic        a_ce, a_ub, a_lb, a_oe, a_we;
  logic [15:0] a_addr, a_din, a_sw;
  logic [15:0] a_dout, a_hex;
  logic        a_valid;

  logic        b_ce, b_ub, b_lb, b_oe, b_we;
  logic [15:0] b_addr, b_din, b_sw;
  logic [15:0] b_dout, b_hex;
  logic        b_valid;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 Clk = ~Clk;

  sram_responder #(.ADDR_W(16), .DEPTH_LOG2(10), .READ_LAT(1)) u_lat1 (
    .Clk(Clk), .Reset(Reset),
    .Mem_CE(a_ce), .Mem_UB(a_ub), .Mem_LB(a_lb), .Mem_OE(a_oe), .Mem_WE(a_we),
    .ADDR(a_addr), .Data_from_CPU(a_din), .Data_to_CPU(a_dout),
    .Rd_valid(a_valid), .Switches(a_sw), .Hex_out(a_hex)
  );

  sram_responder #(.ADDR_W(16), .DEPTH_LOG2(10), .READ_LAT(3)) u_lat3 (
    .Clk(Clk), .Reset(Reset),
    .Mem_CE(b_ce), .Mem_UB(b_ub), .Mem_LB(b_lb), .Mem_OE(b_oe), .Mem_WE(b_we),
    .ADDR(b_addr), .Data_from_CPU(b_din), .Data_to_CPU(b_dout),
    .Rd_valid(b_valid), .Switches(b_sw), .Hex_out(b_hex)
  );

  typedef struct {
    logic        ce, ub, lb, oe, we;
    logic [15:0] addr, din;
    logic        exp_v;
    logic [15:0] exp_d;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic ce, input logic ub, input logic lb,
                             input logic oe, input logic we,
                             input logic [15:0] addr, input logic [15:0] din,
                             input logic exp_v, input logic [15:0] exp_d);
    vec_t r;
    r.ce = ce; r.ub = ub; r.lb = lb; r.oe = oe; r.we = we;
    r.addr = addr; r.din = din; r.exp_v = exp_v; r.exp_d = exp_d;
    return r;
  endfunction

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
      $display("ok   %s: %h", name, act);
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic a_bus(input logic ce, input logic ub, input logic lb,
                       input logic oe, input logic we,
                       input logic [15:0] addr, input logic [15:0] din);
    a_ce = ce; a_ub = ub; a_lb = lb; a_oe = oe; a_we = we;
    a_addr = addr; a_din = din;
  endtask

  task automatic b_bus(input logic ce, input logic oe, input logic we,
                       input logic [15:0] addr, input logic [15:0] din);
    b_ce = ce; b_ub = 1'b0; b_lb = 1'b0; b_oe = oe; b_we = we;
    b_addr = addr; b_din = din;
  endtask

  initial begin
    Reset = 1'b1;
    a_bus(1, 0, 0, 1, 1, 16'h0000, 16'h0000);
    b_bus(1, 1, 1, 16'h0000, 16'h0000);
    a_sw = 16'h0000;
    b_sw = 16'h0000;

    // Reset state
    tick();
    tick();
    check("rst_a_data",  a_dout, 16'h0000);
    check("rst_a_valid", {15'd0, a_valid}, 16'h0000);
    check("rst_a_hex",   a_hex, 16'h0000);
    check("rst_b_data",  b_dout, 16'h0000);
    check("rst_b_valid", {15'd0, b_valid}, 16'h0000);
    Reset = 1'b0;

    //              ce ub lb oe we  addr      din       v  data
    vecs.push_back(v(0, 0, 0, 1, 0, 16'h0005, 16'h1234, 0, 16'h0000));
    vecs.push_back(v(1, 0, 0, 1, 1, 16'h0000, 16'h0000, 0, 16'h0000));
    vecs.push_back(v(0, 0, 0, 0, 1, 16'h0005, 16'h0000, 1, 16'h1234));
    vecs.push_back(v(0, 0, 0, 0, 1, 16'h0005, 16'h0000, 1, 16'h1234));
    vecs.push_back(v(0, 0, 0, 1, 1, 16'h0005, 16'h0000, 0, 16'h1234));
    vecs.push_back(v(0, 0, 0, 1, 0, 16'h0010, 16'hAAAA, 0, 16'h1234));
    vecs.push_back(v(0, 0, 0, 1, 0, 16'h0010, 16'h5555, 0, 16'h1234));
    vecs.push_back(v(0, 0, 0, 1, 0, 16'h0010, 16'h5555, 0, 16'h1234));
    vecs.push_back(v(1, 0, 0, 1, 1, 16'h0000, 16'h0000, 0, 16'h1234));
    vecs.push_back(v(0, 0, 0, 0, 1, 16'h0010, 16'h0000, 1, 16'hAAAA));
    vecs.push_back(v(1, 0, 0, 1, 1, 16'h0000, 16'h0000, 0, 16'hAAAA));
    vecs.push_back(v(0, 0, 0, 1, 0, 16'h0020, 16'hFFFF, 0, 16'hAAAA));
    vecs.push_back(v(1, 0, 0, 1, 1, 16'h0000, 16'h0000, 0, 16'hAAAA));
    vecs.push_back(v(0, 0, 1, 1, 0, 16'h0020, 16'h1200, 0, 16'hAAAA));
    vecs.push_back(v(1, 0, 0, 1, 1, 16'h0000, 16'h0000, 0, 16'hAAAA));
    vecs.push_back(v(0, 0, 0, 0, 1, 16'h0020, 16'h0000, 1, 16'h12FF));
    vecs.push_back(v(0, 1, 0, 0, 1, 16'h0020, 16'h0000, 1, 16'h00FF));
    vecs.push_back(v(1, 0, 0, 1, 1, 16'h0000, 16'h0000, 0, 16'h00FF));
    vecs.push_back(v(0, 0, 0, 0, 1, 16'h0005, 16'h0000, 1, 16'h1234));
    vecs.push_back(v(0, 0, 0, 0, 1, 16'h0010, 16'h0000, 1, 16'hAAAA));
    vecs.push_back(v(1, 0, 0, 1, 1, 16'h0000, 16'h0000, 0, 16'hAAAA));
    vecs.push_back(v(0, 0, 0, 0, 0, 16'h0401, 16'hBEEF, 0, 16'hAAAA));
    vecs.push_back(v(1, 0, 0, 1, 1, 16'h0000, 16'h0000, 0, 16'hAAAA));
    vecs.push_back(v(0, 0, 0, 0, 1, 16'h0001, 16'h0000, 1, 16'hBEEF));
    vecs.push_back(v(0, 0, 0, 0, 1, 16'h0401, 16'h0000, 1, 16'hBEEF));
    vecs.push_back(v(0, 0, 0, 0, 0, 16'h0002, 16'h7777, 0, 16'hBEEF));
    vecs.push_back(v(0, 0, 0, 0, 1, 16'h0002, 16'h0000, 0, 16'hBEEF));
    vecs.push_back(v(0, 0, 0, 0, 1, 16'h0002, 16'h0000, 1, 16'h7777));
    vecs.push_back(v(1, 0, 0, 0, 1, 16'h0002, 16'h0000, 0, 16'h7777));
    vecs.push_back(v(0, 0, 0, 1, 0, 16'h0030, 16'h1111, 0, 16'h7777));
    vecs.push_back(v(1, 0, 0, 1, 1, 16'h0000, 16'h0000, 0, 16'h7777));

    foreach (vecs[i]) begin
      a_bus(vecs[i].ce, vecs[i].ub, vecs[i].lb, vecs[i].oe, vecs[i].we,
            vecs[i].addr, vecs[i].din);
      tick();
      check($sformatf("vec%0d_valid", i), {15'd0, a_valid}, {15'd0, vecs[i].exp_v});
      check($sformatf("vec%0d_data", i), a_dout, vecs[i].exp_d);
    end
    check("table_hex", a_hex, 16'h0000);

    // READ_LAT=3: preload, then a full read
    b_bus(0, 1, 0, 16'h0005, 16'h1234); tick();
    b_bus(1, 1, 1, 16'h0000, 16'h0000); tick();
    b_bus(0, 1, 0, 16'h0006, 16'h0F0F); tick();
    b_bus(1, 1, 1, 16'h0000, 16'h0000); tick();
    b_bus(0, 0, 1, 16'h0005, 16'h0000);
    tick(); check("lat3_e1_valid", {15'd0, b_valid}, 16'h0000);
    tick(); check("lat3_e2_valid", {15'd0, b_valid}, 16'h0000);
    tick(); check("lat3_e3_valid", {15'd0, b_valid}, 16'h0001);
    check("lat3_e3_data", b_dout, 16'h1234);
    tick(); check("lat3_e4_valid", {15'd0, b_valid}, 16'h0001);
    b_bus(1, 1, 1, 16'h0000, 16'h0000);
    tick(); check("lat3_rel_valid", {15'd0, b_valid}, 16'h0000);
    check("lat3_rel_data", b_dout, 16'h1234);

    // READ_LAT=3 abort after one edge, then a clean restart from IDLE
    b_bus(0, 0, 1, 16'h0006, 16'h0000); tick();
    b_bus(1, 1, 1, 16'h0000, 16'h0000);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("lat3_abort%0d_valid", k), {15'd0, b_valid}, 16'h0000);
    end
    check("lat3_abort_data", b_dout, 16'h1234);
    b_bus(0, 0, 1, 16'h0006, 16'h0000);
    tick(); check("lat3_re1_valid", {15'd0, b_valid}, 16'h0000);
    tick(); check("lat3_re2_valid", {15'd0, b_valid}, 16'h0000);
    tick(); check("lat3_re3_data", b_dout, 16'h0F0F);

    // READ_LAT=3: CE-high abort, then a write overriding a pending read
    b_bus(0, 0, 1, 16'h0005, 16'h0000); tick();
    b_bus(1, 0, 1, 16'h0005, 16'h0000); tick();
    check("lat3_ce_abort_valid", {15'd0, b_valid}, 16'h0000);
    b_bus(0, 0, 1, 16'h0005, 16'h0000); tick();
    b_bus(0, 0, 0, 16'h0005, 16'h4321); tick();
    check("lat3_wr_prec_valid", {15'd0, b_valid}, 16'h0000);
    b_bus(1, 1, 1, 16'h0000, 16'h0000); tick();
    b_bus(0, 0, 1, 16'h0005, 16'h0000);
    tick(); tick(); tick();
    check("lat3_wr_prec_data", b_dout, 16'h4321);
    b_bus(1, 1, 1, 16'h0000, 16'h0000); tick();

    // Address 0xFFFF: switch I/O when enabled, wrapped memory otherwise
    a_bus(0, 0, 0, 1, 0, 16'h03FF, 16'h5A5A); tick();
    a_bus(1, 0, 0, 1, 1, 16'h0000, 16'h0000); tick();
    a_sw = 16'h00C3;
    a_bus(0, 0, 0, 0, 1, 16'hFFFF, 16'h0000); tick();
    check("io_rd_valid", {15'd0, a_valid}, 16'h0001);
    check("io_rd_data", a_dout, IO_EN ? 16'h00C3 : 16'h5A5A);
    a_bus(1, 0, 0, 1, 1, 16'h0000, 16'h0000); tick();
    a_bus(0, 0, 0, 1, 0, 16'hFFFF, 16'h0042); tick();
    a_bus(1, 0, 0, 1, 1, 16'h0000, 16'h0000); tick();
    check("io_wr_hex", a_hex, IO_EN ? 16'h0042 : 16'h0000);
    a_bus(0, 0, 0, 0, 1, 16'h03FF, 16'h0000); tick();
    check("io_mem_untouched", a_dout, IO_EN ? 16'h5A5A : 16'h0042);
    a_bus(1, 0, 0, 1, 1, 16'h0000, 16'h0000); tick();
    a_sw = 16'hABCD;
    a_bus(0, 0, 1, 0, 1, 16'hFFFF, 16'h0000); tick();
    check("io_rd_lane", a_dout, IO_EN ? 16'hAB00 : 16'h0000);
    a_bus(1, 0, 0, 1, 1, 16'h0000, 16'h0000); tick();

    // Reset mid-read, and a write strobe that only occurs under reset
    a_bus(0, 0, 0, 0, 1, 16'h0005, 16'h0000); tick();
    check("pre_rst_data", a_dout, 16'h1234);
    Reset = 1'b1;
    #1;
    check("rst_mid_data",  a_dout, 16'h0000);
    check("rst_mid_valid", {15'd0, a_valid}, 16'h0000);
    check("rst_mid_hex",   a_hex, 16'h0000);
    a_bus(0, 0, 0, 1, 0, 16'h0030, 16'h9999);
    tick();
    a_bus(1, 0, 0, 1, 1, 16'h0000, 16'h0000);
    #2;
    Reset = 1'b0;
    tick();
    a_bus(0, 0, 0, 0, 1, 16'h0030, 16'h0000); tick();
    check("rst_drop_wr_data", a_dout, 16'h1111);
    check("rst_drop_wr_valid", {15'd0, a_valid}, 16'h0001);
    a_bus(1, 0, 0, 1, 1, 16'h0000, 16'h0000); tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
